reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64: register data width.
REQ-002 SHALL have parameter NREG, default 32: register count; address width 5.
REQ-003 SHALL have port clock, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port alu_valid, input, 1: ALU writeback request.
REQ-006 SHALL have port alu_ready, output, 1: ALU request granted this cycle.
REQ-007 SHALL have port alu_rd, input, 5: ALU destination register.
REQ-008 SHALL have port alu_data, input, XLEN: ALU result.
REQ-009 SHALL have port lsu_valid, input, 1: load-unit writeback request.
REQ-010 SHALL have port lsu_ready, output, 1: load-unit request granted this cycle.
REQ-011 SHALL have port lsu_rd, input, 5: load destination register.
REQ-012 SHALL have port lsu_data, input, XLEN: load data.
REQ-013 SHALL have port issue_valid, input, 1: an instruction with a destination issues this cycle.
REQ-014 SHALL have port issue_rd, input, 5: destination of the issuing instruction.
REQ-015 SHALL have port regwrite, output, 1: register file write enable.
REQ-016 SHALL have port write_reg, output, 5: register file write address.
REQ-017 SHALL have port write_data, output, XLEN: register file write data.
REQ-018 SHALL have port busy, output, NREG: per-register pending-write bits for hazard stall.

Function
REQ-019 SHALL transfer a request on a rising edge where valid and ready are both 1.
REQ-020 SHALL grant at most one source per cycle; ready depends combinationally on both valids and the priority pointer.
REQ-021 SHALL grant the sole valid source; with both valid, grant the source the pointer names (reset value: ALU).
REQ-022 SHALL move the pointer to the non-granted source after every contended grant; it is unchanged otherwise.
REQ-023 SHALL require a stalled source to hold valid, rd and data stable until granted.
REQ-024 SHALL drive the granted rd/data onto write_reg/write_data, with regwrite=1, exactly one cycle after the transfer edge (registered outputs, latency 1, throughput 1 per cycle).
REQ-025 SHALL, for a granted request with rd=0, complete the handshake but keep regwrite=0 in the following cycle.
REQ-026 SHALL hold write_reg and write_data at their last values while regwrite=0.
REQ-027 SHALL set busy[issue_rd] on an edge with issue_valid=1 and issue_rd!=0; busy[0] is constant 0.
REQ-028 SHALL clear busy[write_reg] on an edge where regwrite=1, i.e. the same edge the register file captures the data.
REQ-029 SHALL give set priority when set and clear target the same register on the same edge.
REQ-030 SHALL NOT reorder writes from one source; cross-source write-after-write ordering to one rd is the issuer's responsibility.

Reset
REQ-031 SHALL, while reset=0, force regwrite=0, write_reg=0, write_data=0, busy=0, pointer=ALU, alu_ready=0, lsu_ready=0, asynchronously.
REQ-032 SHALL discard any transfer in flight when reset asserts mid-operation; no write is issued after release for it.
REQ-033 SHALL resume arbitration on the first rising edge after reset deasserts.

Structure
REQ-034 SHALL take XLEN, NREG, REG_ADDR_W=5 and the source enum (SRC_ALU, SRC_LSU) from shared package reg_wb_pkg.
REQ-035 SHALL place the busy-bit logic in sub-module reg_busy_scoreboard (set/clear ports, busy vector out).

Verification
REQ-036 SHALL cover: only alu_valid=1, alu_rd=1, alu_data=200 -> alu_ready=1; next cycle regwrite=1, write_reg=1, write_data=200.
REQ-037 SHALL cover: both valid for 4 cycles from reset (alu_rd=2, lsu_rd=3) -> grants ALU, LSU, ALU, LSU; writes to 2,3,2,3 on consecutive cycles.
REQ-038 SHALL cover: lsu_valid=1, lsu_rd=0, lsu_data=100 -> lsu_ready=1; next cycle regwrite=0; busy[0] stays 0.
REQ-039 SHALL cover: issue_rd=5, then ALU write to 5 -> busy[5]=1 from issue edge until the edge regwrite=1 with write_reg=5, then 0.
REQ-040 SHALL cover: same-edge issue_rd=5 and regwrite with write_reg=5 -> busy[5] remains 1.
REQ-041 SHALL cover: reset=0 asserted while regwrite=1 -> regwrite, busy, readies drop to 0 immediately; no write after release.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared widths and source identifiers for the register writeback arbiter.
// The default sizes below are also used as the parameter defaults of the modules.
package reg_wb_pkg;

    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_ALU) ? SRC_LSU : SRC_ALU;
    endfunction

endpackage

// File: rtl/reg_busy_scoreboard.sv
// Per-register pending-write bits: set when a writer issues, cleared when its writeback lands.
// A set and a clear of the same register on one edge leave the bit set; bit 0 is never busy.
module reg_busy_scoreboard
    import reg_wb_pkg::*;
#(
    parameter int NREG = reg_wb_pkg::NREG
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    output logic [NREG-1:0]       busy
);

    logic [NREG-1:0] busy_d;

    always_comb begin
        busy_d = busy;
        for (int i = 1; i < NREG; i++) begin
            if (set_en && (set_rd == REG_ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (clr_en && (clr_rd == REG_ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= busy_d;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Two-source (ALU, load unit) register-file writeback arbiter with round-robin on contention,
// one-cycle registered write port and a busy-bit scoreboard for issue hazard stalls.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int XLEN = reg_wb_pkg::XLEN,
    parameter int NREG = reg_wb_pkg::NREG
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  regwrite,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [XLEN-1:0]       write_data,
    output logic [NREG-1:0]       busy
);

    // Handshake: a request transfers on a rising edge where valid && ready. Ready is a
    // combinational grant from both valids and the priority pointer; a source that is not
    // granted must keep valid, rd and data stable until it is.
    src_e                  prio_q;
    src_e                  prio_d;
    logic                  grant_alu;
    logic                  grant_lsu;
    logic                  xfer;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        prio_d    = prio_q;
        if (reset) begin
            if (alu_valid && lsu_valid) begin
                grant_alu = (prio_q == SRC_ALU);
                grant_lsu = (prio_q == SRC_LSU);
                prio_d    = other_src(prio_q);
            end else begin
                grant_alu = alu_valid;
                grant_lsu = lsu_valid;
            end
        end
    end

    assign alu_ready = grant_alu;
    assign lsu_ready = grant_lsu;
    assign xfer      = grant_alu | grant_lsu;
    assign sel_rd    = grant_lsu ? lsu_rd   : alu_rd;
    assign sel_data  = grant_lsu ? lsu_data : alu_data;

    // Writes to x0 complete the handshake but never reach the register file, and leave the
    // write port holding its previous address/data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prio_q     <= SRC_ALU;
            regwrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            prio_q   <= prio_d;
            regwrite <= xfer && (sel_rd != '0);
            if (xfer && (sel_rd != '0)) begin
                write_reg  <= sel_rd;
                write_data <= sel_data;
            end
        end
    end

    reg_busy_scoreboard #(
        .NREG(NREG)
    ) u_busy (
        .clock (clock),
        .reset (reset),
        .set_en(issue_valid),
        .set_rd(issue_rd),
        .clr_en(regwrite),
        .clr_rd(write_reg),
        .busy  (busy)
    );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios plus a randomized run against
// a queue-based reference model of grants, writes and busy bits.
module tb_reg_wb_arbiter;

    localparam int XLEN = 64;
    localparam int NREG = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            regwrite;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;
    logic [NREG-1:0] busy;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: {write_enable, rd, data} expected after each edge
    logic [XLEN+5:0] exp_q[$];
    bit              m_ptr_lsu;
    bit              m_busy[NREG];

    reg_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clock      (clock),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .regwrite   (regwrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        issue_valid = 1'b0; issue_rd = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        alu_valid = 1'b1; lsu_valid = 1'b1; alu_rd = 5'd3; lsu_rd = 5'd4;
        issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        tick();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %0b expected 0", regwrite); end
        n_tests++; if (write_reg !== 5'd0) begin n_fail++; $display("FAIL reset_write_reg: got %0d expected 0", write_reg); end
        n_tests++; if (write_data !== 64'd0) begin n_fail++; $display("FAIL reset_write_data: got %0h expected 0", write_data); end
        n_tests++; if (busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h expected 0", busy); end
        n_tests++; if ({alu_ready, lsu_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", {alu_ready, lsu_ready}); end
        idle_inputs();
        reset = 1'b1;
        tick();
        n_tests++; if (regwrite !== 1'b0 || busy !== 32'd0) begin n_fail++; $display("FAIL post_reset_idle: got regwrite=%0b busy=%h expected 0/0", regwrite, busy); end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'd200;
        #1;
        n_tests++; if ({alu_ready, lsu_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b expected 10", {alu_ready, lsu_ready}); end
        tick();
        alu_valid = 1'b0;
        n_tests++; if (regwrite !== 1'b1) begin n_fail++; $display("FAIL single_regwrite: got %0b expected 1", regwrite); end
        n_tests++; if (write_reg !== 5'd1) begin n_fail++; $display("FAIL single_write_reg: got %0d expected 1", write_reg); end
        n_tests++; if (write_data !== 64'd200) begin n_fail++; $display("FAIL single_write_data: got %0d expected 200", write_data); end
        tick();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL single_regwrite_drop: got %0b expected 0", regwrite); end
        n_tests++; if (write_reg !== 5'd1 || write_data !== 64'd200) begin n_fail++; $display("FAIL single_hold: got %0d/%0d expected 1/200", write_reg, write_data); end
    endtask

    // Pointer is still at its reset value here; the single ALU grant was uncontended.
    task automatic test_contended();
        logic [4:0]      exp_rd;
        logic [XLEN-1:0] exp_data;
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'(10 + k);
            lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 64'(20 + k);
            exp_rd   = (k % 2 == 0) ? 5'd2 : 5'd3;
            exp_data = (k % 2 == 0) ? 64'(10 + k) : 64'(20 + k);
            #1;
            n_tests++; if ({alu_ready, lsu_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL contend_grant%0d: got %b expected %s", k, {alu_ready, lsu_ready}, (k % 2 == 0) ? "10" : "01"); end
            tick();
            n_tests++; if (regwrite !== 1'b1 || write_reg !== exp_rd || write_data !== exp_data) begin n_fail++; $display("FAIL contend_write%0d: got %0b/%0d/%0d expected 1/%0d/%0d", k, regwrite, write_reg, write_data, exp_rd, exp_data); end
        end
        idle_inputs();
    endtask

    task automatic test_rd_zero();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'd100;
        #1;
        n_tests++; if ({alu_ready, lsu_ready} !== 2'b01) begin n_fail++; $display("FAIL rd0_ready: got %b expected 01", {alu_ready, lsu_ready}); end
        tick();
        lsu_valid = 1'b0;
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL rd0_regwrite: got %0b expected 0", regwrite); end
        n_tests++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL rd0_busy0: got %0b expected 0", busy[0]); end
        n_tests++; if (write_reg !== 5'd3 || write_data !== 64'd23) begin n_fail++; $display("FAIL rd0_hold: got %0d/%0d expected 3/23", write_reg, write_data); end
    endtask

    task automatic test_busy();
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        n_tests++; if (busy !== 32'd0) begin n_fail++; $display("FAIL busy_issue_x0: got %h expected 0", busy); end
        issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0;
        n_tests++; if (busy !== 32'h20) begin n_fail++; $display("FAIL busy_set: got %h expected 00000020", busy); end
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'd55;
        tick();
        alu_valid = 1'b0;
        n_tests++; if (regwrite !== 1'b1 || write_reg !== 5'd5 || busy[5] !== 1'b1) begin n_fail++; $display("FAIL busy_pending: got rw=%0b wr=%0d busy5=%0b expected 1/5/1", regwrite, write_reg, busy[5]); end
        tick();
        n_tests++; if (busy[5] !== 1'b0) begin n_fail++; $display("FAIL busy_clear: got %0b expected 0", busy[5]); end
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'd66;
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        issue_valid = 1'b0;
        n_tests++; if (busy[5] !== 1'b1) begin n_fail++; $display("FAIL busy_set_wins: got %0b expected 1", busy[5]); end
    endtask

    task automatic test_random();
        logic [XLEN+5:0] e;
        logic [NREG-1:0] exp_busy;
        logic [1:0]      g;
        logic            cur_v;
        logic [4:0]      cur_r;
        logic [4:0]      last_reg;
        logic [XLEN-1:0] last_data;
        bit              alu_hold;
        bit              lsu_hold;
        apply_reset();
        exp_q.delete();
        m_ptr_lsu = 1'b0;
        for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        last_reg = '0; last_data = '0; alu_hold = 1'b0; lsu_hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            cur_v = e[XLEN+5];
            cur_r = e[XLEN+4:XLEN];
            if (cur_v) begin last_reg = cur_r; last_data = e[XLEN-1:0]; end
            for (int i = 0; i < NREG; i++) exp_busy[i] = m_busy[i];
            n_tests++; if (regwrite !== cur_v) begin n_fail++; $display("FAIL rand_regwrite c=%0d: got %0b expected %0b", c, regwrite, cur_v); end
            n_tests++; if (write_reg !== last_reg || write_data !== last_data) begin n_fail++; $display("FAIL rand_port c=%0d: got %0d/%h expected %0d/%h", c, write_reg, write_data, last_reg, last_data); end
            n_tests++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rand_busy c=%0d: got %h expected %h", c, busy, exp_busy); end
            if (!alu_hold) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_rd = 5'($urandom_range(0, 31));
                alu_data = {$urandom(), $urandom()};
            end
            if (!lsu_hold) begin
                lsu_valid = ($urandom_range(0, 99) < 60);
                lsu_rd = 5'($urandom_range(0, 31));
                lsu_data = {$urandom(), $urandom()};
            end
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_rd = 5'($urandom_range(0, 31));
            // grant vector {lsu, alu}: sole requester wins, otherwise the pointer's choice
            if (alu_valid && lsu_valid) g = m_ptr_lsu ? 2'b10 : 2'b01;
            else g = {lsu_valid, alu_valid};
            #1;
            n_tests++; if ({lsu_ready, alu_ready} !== g) begin n_fail++; $display("FAIL rand_ready c=%0d: got %b expected %b", c, {lsu_ready, alu_ready}, g); end
            if (cur_v) m_busy[cur_r] = 1'b0;
            if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
            if (g[0]) exp_q.push_back({alu_rd != 5'd0, alu_rd, alu_data});
            else if (g[1]) exp_q.push_back({lsu_rd != 5'd0, lsu_rd, lsu_data});
            else exp_q.push_back('0);
            if (alu_valid && lsu_valid) m_ptr_lsu = g[0];
            alu_hold = alu_valid && !g[0];
            lsu_hold = lsu_valid && !g[1];
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'd77;
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0;
        n_tests++; if (regwrite !== 1'b1 || busy[9] !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got rw=%0b busy9=%0b expected 1/1", regwrite, busy[9]); end
        reset = 1'b0;
        #1;
        n_tests++; if (regwrite !== 1'b0 || write_reg !== 5'd0 || write_data !== 64'd0) begin n_fail++; $display("FAIL mid_port: got %0b/%0d/%0d expected 0/0/0", regwrite, write_reg, write_data); end
        n_tests++; if (busy !== 32'd0) begin n_fail++; $display("FAIL mid_busy: got %h expected 0", busy); end
        n_tests++; if ({alu_ready, lsu_ready} !== 2'b00) begin n_fail++; $display("FAIL mid_ready: got %b expected 00", {alu_ready, lsu_ready}); end
        tick();
        tick();
        alu_valid = 1'b0;
        reset = 1'b1;
        tick();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL mid_release1: got %0b expected 0", regwrite); end
        tick();
        n_tests++; if (regwrite !== 1'b0) begin n_fail++; $display("FAIL mid_release2: got %0b expected 0", regwrite); end
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'd44;
        #1;
        n_tests++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL resume_ready: got %0b expected 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        n_tests++; if (regwrite !== 1'b1 || write_reg !== 5'd4 || write_data !== 64'd44) begin n_fail++; $display("FAIL resume_write: got %0b/%0d/%0d expected 1/4/44", regwrite, write_reg, write_data); end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_single_alu();
        test_contended();
        test_rd_zero();
        test_busy();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
